// File: rtl/frame_sync_rx.sv
// Serial sync-word receiver: hunts for the ASM, verifies over consecutive frames,
// then flywheels frame timing and forwards payload bits through one output register.
module frame_sync_rx #(
  parameter int          SYNC_LEN     = 32,
  parameter logic [31:0] SYNC_WORD    = 32'h1ACFFC1D,
  parameter int          MAX_ERR      = 2,
  parameter int          VERIFY_COUNT = 2,
  parameter int          LOSS_COUNT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] frame_length,
  input  logic        s_valid,
  input  logic        s_bit,
  output logic        s_ready,
  output logic        m_valid,
  output logic        m_bit,
  input  logic        m_ready,
  output logic        start_frame,
  output logic        end_frame,
  output logic        locked,
  output logic        sync_lost
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [15:0]         EVAL_OFS = 16'(SYNC_LEN - 1);
  localparam logic [5:0]          FILL_MAX = 6'(SYNC_LEN);

  state_e              state_q, state_d;
  logic [SYNC_LEN-1:0] sr_q, sr_d;
  logic [5:0]          fill_q, fill_d;
  logic [15:0]         fl_q, fl_d;
  logic [15:0]         pos_q, pos_d;
  logic [7:0]          verify_cnt_q, verify_cnt_d;
  logic [7:0]          miss_cnt_q, miss_cnt_d;
  logic                m_valid_q, m_valid_d;
  logic                m_bit_q, m_bit_d;
  logic                start_q, start_d;
  logic                end_q, end_d;
  logic                sync_lost_q, sync_lost_d;

  logic                accept, match, eval_pt, payload;
  logic [SYNC_LEN-1:0] sr_next, diff;
  logic [5:0]          err_cnt;
  logic [15:0]         fl_in;

  assign sr_next = {sr_q[SYNC_LEN-2:0], s_bit};

  for (genvar gi = 0; gi < SYNC_LEN; gi++) begin : g_diff
    assign diff[gi] = sr_next[gi] ^ SYNC_PAT[gi];
  end

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      err_cnt = err_cnt + 6'(diff[i]);
    end
  end

  assign match   = (err_cnt <= 6'(MAX_ERR));
  // Frames shorter than two payload bits are stretched so start/end stay distinct beats.
  assign fl_in   = (frame_length < 13'd2) ? 16'd2 : {3'b000, frame_length};
  assign eval_pt = (pos_q == fl_q + EVAL_OFS);
  assign payload = (pos_q < fl_q);
  assign s_ready = (state_q != LOCKED) | m_ready | ~m_valid_q;
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    fill_d       = fill_q;
    fl_d         = fl_q;
    pos_d        = pos_q;
    verify_cnt_d = verify_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    m_valid_d    = m_valid_q & ~m_ready;
    m_bit_d      = m_bit_q;
    start_d      = start_q;
    end_d        = end_q;
    sync_lost_d  = 1'b0;
    if (accept) begin
      sr_d  = sr_next;
      pos_d = pos_q + 16'd1;
      if (fill_q != FILL_MAX) fill_d = fill_q + 6'd1;
      case (state_q)
        HUNT: begin
          if ((fill_q >= FILL_MAX - 6'd1) && match) begin
            state_d      = VERIFY;
            pos_d        = '0;
            verify_cnt_d = '0;
            fl_d         = fl_in;
          end
        end
        VERIFY: begin
          if (eval_pt) begin
            pos_d = '0;
            fl_d  = fl_in;
            if (!match) begin
              state_d = HUNT;
            end else if (verify_cnt_q + 8'd1 == 8'(VERIFY_COUNT)) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end else begin
              verify_cnt_d = verify_cnt_q + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (payload) begin
            m_valid_d = 1'b1;
            m_bit_d   = s_bit;
            start_d   = (pos_q == 16'd0);
            end_d     = (pos_q == fl_q - 16'd1);
          end
          // Misses keep the frame timing; only LOSS_COUNT in a row drops lock.
          if (eval_pt) begin
            pos_d = '0;
            fl_d  = fl_in;
            if (match) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q + 8'd1 == 8'(LOSS_COUNT)) begin
              state_d     = HUNT;
              miss_cnt_d  = '0;
              sync_lost_d = 1'b1;
            end else begin
              miss_cnt_d = miss_cnt_q + 8'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      fill_q       <= '0;
      fl_q         <= '0;
      pos_q        <= '0;
      verify_cnt_q <= '0;
      miss_cnt_q   <= '0;
      m_valid_q    <= 1'b0;
      m_bit_q      <= 1'b0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      sync_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      fill_q       <= fill_d;
      fl_q         <= fl_d;
      pos_q        <= pos_d;
      verify_cnt_q <= verify_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      m_valid_q    <= m_valid_d;
      m_bit_q      <= m_bit_d;
      start_q      <= start_d;
      end_q        <= end_d;
      sync_lost_q  <= sync_lost_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_bit       = m_bit_q;
  assign start_frame = start_q;
  assign end_frame   = end_q;
  assign locked      = (state_q == LOCKED);
  assign sync_lost   = sync_lost_q;

endmodule

// File: tb/tb_frame_sync_rx.sv
// Directed bench for frame_sync_rx: lock acquisition, bit errors, loss of lock,
// backpressure, mid-frame reset and the minimum frame length.
module tb_frame_sync_rx;

  localparam logic [31:0] ASM = 32'h1ACFFC1D;

  logic        clk;
  logic        rst;
  logic [12:0] frame_length;
  logic        s_valid;
  logic        s_bit;
  logic        s_ready;
  logic        m_valid;
  logic        m_bit;
  logic        m_ready;
  logic        start_frame;
  logic        end_frame;
  logic        locked;
  logic        sync_lost;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit bp_mode = 0;

  logic [2:0] got_q[$];
  logic [2:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [2:0] stall_val  = 3'b000;

  frame_sync_rx dut (
    .clk         (clk),
    .rst         (rst),
    .frame_length(frame_length),
    .s_valid     (s_valid),
    .s_bit       (s_bit),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_bit       (m_bit),
    .m_ready     (m_ready),
    .start_frame (start_frame),
    .end_frame   (end_frame),
    .locked      (locked),
    .sync_lost   (sync_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Downstream ready: always high, or high one cycle in three under backpressure.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      m_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  // Output monitor: records handshakes and checks that stalled beats hold still.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", 32'(m_valid), 32'd1);
        check_eq("stall_hold", 32'({m_bit, start_frame, end_frame}), 32'(stall_val));
      end
      if (m_valid && m_ready) got_q.push_back({m_bit, start_frame, end_frame});
      stall_prev = m_valid && !m_ready;
      if (stall_prev) begin
        stall_val = {m_bit, start_frame, end_frame};
        if (locked) check_eq("stall_s_ready", 32'(s_ready), 32'd0);
      end
    end
  end

  task automatic send_bit(input logic b);
    logic acc;
    int   guard;
    guard   = 0;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_bit   = b;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic send_asm(input int nerr);
    logic [31:0] w;
    w = ASM;
    for (int i = 0; i < nerr; i++) w[31 - i * 7] = ~w[31 - i * 7];
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  // Payload positions first..last of a frame whose length is fl.
  task automatic send_payload(input int first, input int last, input int fl, input bit expect_out);
    logic b;
    for (int i = first; i <= last; i++) begin
      b = logic'($urandom_range(0, 1));
      if (expect_out) exp_q.push_back({b, logic'(i == 0), logic'(i == fl - 1)});
      send_bit(b);
    end
  endtask

  task automatic verify_stream(input string tag);
    int n;
    repeat (8) @(posedge clk);
    #1;
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    $display("[TB] stream %s: %0d beats received, %0d expected", tag, got_q.size(), exp_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    s_valid      = 1'b0;
    s_bit        = 1'b0;
    frame_length = 13'd100;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_sync_lost", 32'(sync_lost), 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;

    // Clean lock: random lead-in, then four ASM+100 frames.
    send_payload(0, 39, 1000, 0);
    send_asm(0);
    send_payload(0, 99, 100, 0);
    check_eq("lock_after_asm1", 32'(locked), 32'd0);
    send_asm(0);
    check_eq("lock_after_asm2", 32'(locked), 32'd0);
    send_payload(0, 99, 100, 0);
    send_asm(0);
    check_eq("lock_after_asm3", 32'(locked), 32'd1);
    send_payload(0, 99, 100, 1);
    send_asm(0);
    send_payload(0, 99, 100, 1);
    verify_stream("clean_lock");

    // One 3-error ASM is flywheeled; a 2-error ASM counts as a match.
    send_asm(3);
    check_eq("flywheel_locked", 32'(locked), 32'd1);
    send_payload(0, 99, 100, 1);
    send_asm(2);
    send_payload(0, 99, 100, 1);
    send_asm(3);
    check_eq("miss1_locked", 32'(locked), 32'd1);
    send_payload(0, 99, 100, 1);
    send_asm(3);
    check_eq("miss2_locked", 32'(locked), 32'd1);
    send_payload(0, 99, 100, 1);
    send_asm(3);
    check_eq("loss_locked", 32'(locked), 32'd0);
    check_eq("loss_pulse", 32'(sync_lost), 32'd1);
    @(posedge clk);
    #1;
    check_eq("loss_pulse_end", 32'(sync_lost), 32'd0);
    send_payload(0, 99, 100, 0);
    verify_stream("errors_and_loss");

    // In HUNT a 3-error ASM must not start verification.
    send_asm(3);
    send_payload(0, 99, 100, 0);
    send_asm(0);
    send_payload(0, 99, 100, 0);
    send_asm(0);
    check_eq("hunt_3err_ignored", 32'(locked), 32'd0);
    send_payload(0, 99, 100, 0);
    send_asm(0);
    check_eq("relock", 32'(locked), 32'd1);

    // Backpressure: ready one cycle in three.
    bp_mode = 1;
    send_payload(0, 99, 100, 1);
    send_asm(0);
    send_payload(0, 99, 100, 1);
    bp_mode = 0;
    verify_stream("backpressure");

    // Reset while payload bit 49 sits in the output stage.
    send_asm(0);
    send_payload(0, 48, 100, 1);
    send_payload(49, 49, 100, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_m_valid", 32'(m_valid), 32'd0);
    check_eq("midrst_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    verify_stream("mid_reset");
    send_asm(2);
    send_payload(0, 99, 100, 0);
    send_asm(0);
    send_payload(0, 99, 100, 0);
    send_asm(0);
    check_eq("postrst_relock", 32'(locked), 32'd1);

    // Short frames and mid-frame frame_length changes.
    send_payload(0, 49, 100, 1);
    frame_length = 13'd0;
    send_payload(50, 99, 100, 1);
    send_asm(0);
    send_payload(0, 1, 2, 1);
    frame_length = 13'd1;
    send_asm(0);
    send_payload(0, 1, 2, 1);
    send_asm(0);
    send_payload(0, 0, 2, 1);
    frame_length = 13'd200;
    send_payload(1, 1, 2, 1);
    send_asm(0);
    send_payload(0, 199, 200, 1);
    send_asm(0);
    check_eq("fl200_locked", 32'(locked), 32'd1);
    verify_stream("short_frames");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
